vga_capture: RTL and testbench
==============================

# vga_capture

Captures a 640x480@60 VGA pixel stream (4:4:4 RGB, separate active-low syncs) and writes a 2^DS-decimated copy of each frame into the 12-bit-per-pixel framebuffer BRAM. It is the input-side counterpart of the VGA output path: that path reads the framebuffer and drives the monitor, while this block fills the framebuffer from an external VGA source. It runs entirely in the 25 MHz pixel clock domain. It contains sync edge detection, line and pixel counters, a capture FSM and a running BRAM write-address generator.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_BP, 48, back-porch clocks between the end of hsync and the first active pixel
- V_ACTIVE, 480, active lines per frame
- V_BP, 33, back-porch lines after the end of vsync
- DS, 1, decimation shift; keeps 1 of every 2^DS pixels in x and in y
- ADDR_W, 17, BRAM address width; must satisfy 2^ADDR_W >= (H_ACTIVE>>DS)*(V_ACTIVE>>DS)

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  synchronous, active-high reset
- capture_en  in  1  enables capture; sampled only at frame start
- vga_in_r, vga_in_g, vga_in_b  in  4 each  pixel colour
- vga_in_hs, vga_in_vs  in  1 each  syncs, active low
- bram_we  out  1  write strobe, one cycle per stored pixel
- bram_addr  out  ADDR_W  write address
- bram_wdata  out  12  pixel data as {r,g,b}
- frame_done  out  1  one-cycle pulse after a complete frame
- busy  out  1  high in VSYNC and LINES
- sync_err  out  1  one-cycle pulse when a malformed frame is aborted

## Operation
- Input stage: all inputs are registered once. All logic below uses the registered copies.
- Edge detection on the registered syncs:
  - vs_fall: vsync start.
  - vs_rise: vsync end.
  - hs_rise: hsync end.
- hcnt: set to 0 on the hs_rise cycle, then increments each clock and saturates at 2047. Pixel x = hcnt - H_BP, valid for hcnt in [H_BP, H_BP+H_ACTIVE).
- vcnt: cleared on vs_rise and incremented on each hs_rise. The first hs_rise after vs_rise gives vcnt = 0. Line y = vcnt - V_BP, valid for vcnt in [V_BP, V_BP+V_ACTIVE).
- A pixel is stored when x and y are both valid and the low DS bits of x and of y are zero.
- bram_addr starts at 0 at frame start and increments by 1 after each store. There is no multiplier. The final store uses address (H_ACTIVE>>DS)*(V_ACTIVE>>DS)-1.
- FSM states and transitions:
  - IDLE → WAIT_VS when capture_en = 1.
  - WAIT_VS → VSYNC on vs_fall if capture_en = 1; back to IDLE if capture_en = 0.
  - VSYNC → LINES on vs_rise. bram_addr is cleared here.
  - LINES: stores pixels. Goes to DONE when the store cycle of the last active pixel completes.
  - DONE: one cycle; frame_done = 1. Then → WAIT_VS if capture_en = 1, else IDLE.
- Error conditions in LINES. Each one pulses sync_err, suppresses further writes and returns the FSM to WAIT_VS:
  - vs_fall before the frame completes. The same vs_fall cycle does not re-arm; the FSM re-arms on the next vs_fall.
  - hs_rise while hcnt < H_BP+H_ACTIVE (short line).
  - hcnt reaching 2047 (missing hsync).
- Deasserting capture_en mid-frame does not abort the frame; it takes effect at the next WAIT_VS/DONE decision.
- Reset values: all outputs 0, FSM in IDLE, all counters 0, registered syncs 1 (the idle level).

## Timing
- Pixel on the input pins at cycle t → bram_we/bram_addr/bram_wdata registered and valid at t+2. Fixed 2-cycle latency.
- All outputs are registered; no combinational path from input to output.
- frame_done is asserted the cycle after the final bram_we.
- sync_err is asserted 2 cycles after the offending edge reaches the pins.
- bram_we is never high in IDLE, WAIT_VS, VSYNC or DONE.
- rst mid-frame: the next cycle has bram_we = 0 and the FSM in IDLE. No partial-frame frame_done is issued.

## Test plan
- Small frame (H_ACTIVE=8, H_BP=4, V_ACTIVE=4, V_BP=2, DS=1, pixel value = {y,x} pattern), capture_en = 1 → exactly 8 writes at addresses 0..7 in order, each with the expected pixel value; one frame_done pulse, on the cycle after write 7.
- Default parameters, full 800x525 timing, two consecutive frames → 76800 writes per frame with the final address 76799; two frame_done pulses; busy low only outside VSYNC/LINES.
- vsync pulled low after 2 active lines of the small frame → sync_err pulse; no further writes; no frame_done; the next full frame captures correctly starting at address 0.
- Short line: hs_rise at hcnt = 6 during active video → sync_err, writes stop, FSM returns to WAIT_VS.
- capture_en deasserted mid-frame → the current frame completes with frame_done; the FSM then goes to IDLE and the following frame produces zero writes.
- rst asserted for one cycle mid-line → all outputs 0 on the next cycle; with capture_en held high, capture restarts at the next vs_fall.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: samples a VGA pixel stream and writes a 2^DS-decimated copy of
// each active frame into the framebuffer BRAM, one word per kept pixel.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_BP     = 33,
  parameter int DS       = 1,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_en,
  input  logic [3:0]        vga_in_r,
  input  logic [3:0]        vga_in_g,
  input  logic [3:0]        vga_in_b,
  input  logic              vga_in_hs,
  input  logic              vga_in_vs,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [11:0]       bram_wdata,
  output logic              frame_done,
  output logic              busy,
  output logic              sync_err
);

  localparam logic [10:0] CMAX    = 11'h7FF;
  localparam logic [10:0] H_BEG   = 11'(H_BP);
  localparam logic [10:0] H_END   = 11'(H_BP + H_ACTIVE);
  localparam logic [10:0] V_BEG   = 11'(V_BP);
  localparam logic [10:0] V_END   = 11'(V_BP + V_ACTIVE);
  localparam logic [10:0] DS_MASK = 11'((1 << DS) - 1);
  localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - (1 << DS));
  localparam logic [10:0] Y_LAST  = 11'(V_ACTIVE - (1 << DS));

  typedef enum logic [2:0] {IDLE, WAIT_VS, VSYNC, LINES, DONE} state_t;
  state_t state, nstate;

  logic [3:0]        r_q, g_q, b_q;
  logic              hs_q, vs_q, hs_d, vs_d, en_q;
  logic [10:0]       hcnt, vcnt;
  logic              vfirst;
  logic [ADDR_W-1:0] waddr;
  logic              last_q;

  logic        hs_rise, vs_rise, vs_fall;
  logic [10:0] h, x, y;
  logic        x_ok, y_ok, line_act, keep, is_last, err, store;

  // Input stage plus one extra sync delay for edge detection; syncs idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0; g_q <= '0; b_q <= '0;
      hs_q <= 1'b1; vs_q <= 1'b1; hs_d <= 1'b1; vs_d <= 1'b1;
      en_q <= 1'b0;
    end else begin
      r_q <= vga_in_r; g_q <= vga_in_g; b_q <= vga_in_b;
      hs_q <= vga_in_hs; vs_q <= vga_in_vs;
      hs_d <= hs_q; vs_d <= vs_q;
      en_q <= capture_en;
    end
  end

  assign hs_rise = hs_q & ~hs_d;
  assign vs_rise = vs_q & ~vs_d;
  assign vs_fall = ~vs_q & vs_d;

  // The hs_rise cycle counts as hcnt 0, so the register already holds 1 after it.
  assign h = hs_rise ? 11'd0 : hcnt;
  assign x = h - H_BEG;
  assign y = vcnt - V_BEG;

  assign x_ok     = (h >= H_BEG) && (h < H_END);
  assign line_act = !vfirst && (vcnt >= V_BEG) && (vcnt < V_END);
  assign y_ok     = line_act;
  assign keep     = ((x | y) & DS_MASK) == 11'd0;
  assign is_last  = (x == X_LAST) && (y == Y_LAST);

  // Malformed-frame detection; once the last store is out the frame is done.
  assign err = (state == LINES) && !last_q &&
               (vs_fall || (h == CMAX) || (hs_rise && line_act && (hcnt < H_END)));
  assign store = (state == LINES) && x_ok && y_ok && keep && !err;

  // Pixel/line counters; vfirst marks "no hs_rise yet since vsync ended".
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt   <= '0;
      vcnt   <= '0;
      vfirst <= 1'b0;
    end else begin
      hcnt <= hs_rise ? 11'd1 : ((hcnt == CMAX) ? CMAX : hcnt + 11'd1);
      if (vs_rise) begin
        vcnt   <= '0;
        vfirst <= 1'b1;
      end else if (hs_rise) begin
        vcnt   <= vfirst ? 11'd0 : ((vcnt == CMAX) ? CMAX : vcnt + 11'd1);
        vfirst <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // FSM next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (en_q) nstate = WAIT_VS;
      WAIT_VS: if (!en_q) nstate = IDLE;
               else if (vs_fall) nstate = VSYNC;
      VSYNC:   if (vs_rise) nstate = LINES;
      LINES:   if (last_q) nstate = DONE;
               else if (err) nstate = WAIT_VS;
      DONE:    nstate = en_q ? WAIT_VS : IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Registered write port, status pulses and the running write address.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      sync_err   <= 1'b0;
      waddr      <= '0;
      last_q     <= 1'b0;
    end else begin
      bram_we    <= store;
      sync_err   <= err;
      last_q     <= store && is_last;
      frame_done <= (state == LINES) && last_q;
      busy       <= (nstate == VSYNC) || (nstate == LINES);
      if (state == VSYNC)  waddr <= '0;
      else if (store)      waddr <= waddr + 1'b1;
      if (store) begin
        bram_addr  <= waddr;
        bram_wdata <= {r_q, g_q, b_q};
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a shrunken 8x4 frame (16-clock lines,
// 9-line frames): normal capture, back-to-back frames, vsync abort, short
// line, missing hsync, capture_en drop and mid-line reset.
module tb_vga_capture;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          capture_en = 1'b0;
  logic [3:0]    vga_in_r = '0, vga_in_g = '0, vga_in_b = '0;
  logic          vga_in_hs = 1'b1, vga_in_vs = 1'b1;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [11:0]   bram_wdata;
  logic          frame_done, busy, sync_err;

  vga_capture #(.H_ACTIVE(8), .H_BP(4), .V_ACTIVE(4), .V_BP(2), .DS(1), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en),
    .vga_in_r(vga_in_r), .vga_in_g(vga_in_g), .vga_in_b(vga_in_b),
    .vga_in_hs(vga_in_hs), .vga_in_vs(vga_in_vs),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .frame_done(frame_done), .busy(busy), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output log, sampled mid-cycle.
  logic [AW-1:0] wa[$];
  logic [11:0]   wd[$];
  int            wc[$];
  int wr_n = 0, fd_n = 0, err_n = 0, busy_n = 0, nobusy_n = 0, fd_cyc = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (bram_we) begin
      wa.push_back(bram_addr); wd.push_back(bram_wdata); wc.push_back(cyc);
      wr_n <= wr_n + 1;
      if (!busy) nobusy_n <= nobusy_n + 1;
    end
    if (frame_done) begin fd_n <= fd_n + 1; fd_cyc <= cyc; end
    if (sync_err)   begin err_n <= err_n + 1; err_cyc <= cyc; end
    if (busy) busy_n <= busy_n + 1;
  end

  int   n_vec = 0, n_err = 0;
  int   px0_cyc = 0, vsf_cyc = 0;
  logic last_vs = 1'b1;
  int   wb, fb, eb, bb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int i);
    logic [3:0] px, py;
    py = 4'((i / 4) * 2);
    px = 4'((i % 4) * 2);
    return {py, px, px ^ py};
  endfunction

  task automatic tick(input logic hs, input logic vs, input logic [3:0] r, g, b, input logic rs);
    vga_in_hs = hs; vga_in_vs = vs; vga_in_r = r; vga_in_g = g; vga_in_b = b; rst = rs;
    if (last_vs && !vs) vsf_cyc = cyc;
    last_vs = vs;
    @(posedge clk); #1;
  endtask

  // One line: 2 clocks hsync low, hi_len clocks high; active pixels at hcnt 4..11.
  task automatic line(input logic vs, input int y, input int hi_len, input int rst_at);
    for (int c = 0; c < 2 + hi_len; c++) begin
      int hh;
      logic [3:0] px, py;
      hh = c - 2;
      px = 4'(hh - 4);
      py = 4'(y);
      if (y >= 0 && hh >= 4 && hh < 12) begin
        if (y == 0 && hh == 4) px0_cyc = cyc;
        tick(c >= 2, vs, py, px, px ^ py, c == rst_at);
      end else
        tick(c >= 2, vs, 4'd0, 4'd0, 4'd0, c == rst_at);
      if (c == rst_at) begin
        chk("rst_we", 32'(bram_we), 0);
        chk("rst_addr", 32'(bram_addr), 0);
        chk("rst_data", 32'(bram_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_err", 32'(sync_err), 0);
      end
    end
  endtask

  // 2 vsync lines, 2 back-porch lines, 4 active lines, 1 front-porch line.
  task automatic frame(input int abort_y, input int odd_y, input int odd_len,
                       input int en_off_y, input int rst_y);
    line(1'b0, -1, 14, -1); line(1'b0, -1, 14, -1);
    line(1'b1, -1, 14, -1); line(1'b1, -1, 14, -1);
    for (int y = 0; y < 4; y++) begin
      if (y == abort_y) begin
        line(1'b0, -1, 14, -1); line(1'b0, -1, 14, -1);
        line(1'b1, -1, 14, -1); line(1'b1, -1, 14, -1);
        return;
      end
      if (y == en_off_y) capture_en = 1'b0;
      line(1'b1, y, (y == odd_y) ? odd_len : 14, (y == rst_y) ? 9 : -1);
    end
    line(1'b1, -1, 14, -1);
  endtask

  task automatic snap();
    wb = wr_n; fb = fd_n; eb = err_n; bb = busy_n;
  endtask

  task automatic chk_writes(input string tag, input int exp_n, input bit dat);
    chk({tag, "_count"}, 32'(wr_n - wb), 32'(exp_n));
    for (int i = 0; i < exp_n && wb + i < wr_n; i++) begin
      chk({tag, "_addr"}, 32'(wa[wb + i]), 32'(i));
      if (dat) chk({tag, "_data"}, 32'(wd[wb + i]), 32'(pix(i)));
    end
  endtask

  initial begin
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1);
    chk("reset_we", 32'(bram_we), 0);
    chk("reset_addr", 32'(bram_addr), 0);
    chk("reset_data", 32'(bram_wdata), 0);
    chk("reset_done", 32'(frame_done), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_err", 32'(sync_err), 0);

    capture_en = 1'b1;
    line(1'b1, -1, 14, -1); line(1'b1, -1, 14, -1);

    // Normal frame: 8 writes, latency 2, frame_done right after last write.
    snap();
    frame(-1, -1, 14, -1, -1);
    chk_writes("t1", 8, 1'b1);
    chk("t1_done_n", 32'(fd_n - fb), 1);
    chk("t1_err_n", 32'(err_n - eb), 0);
    if (wr_n > wb) begin
      chk("t1_latency", 32'(wc[wb]), 32'(px0_cyc + 2));
      chk("t1_done_cyc", 32'(fd_cyc), 32'(wc[wr_n - 1] + 1));
    end
    chk("t1_busy_seen", 32'(busy_n - bb > 0), 1);
    chk("t1_we_nobusy", 32'(nobusy_n), 0);
    chk("t1_busy_end", 32'(busy), 0);

    // Back-to-back frame restarts at address 0.
    snap();
    frame(-1, -1, 14, -1, -1);
    chk_writes("t2", 8, 1'b1);
    chk("t2_done_n", 32'(fd_n - fb), 1);

    // vsync falls after 2 active lines: abort, then a clean frame.
    snap();
    frame(2, -1, 14, -1, -1);
    chk_writes("t3_abort", 4, 1'b1);
    chk("t3_err_n", 32'(err_n - eb), 1);
    chk("t3_err_cyc", 32'(err_cyc), 32'(vsf_cyc + 2));
    chk("t3_done_n", 32'(fd_n - fb), 0);
    snap();
    frame(-1, -1, 14, -1, -1);
    chk_writes("t3_next", 8, 1'b1);
    chk("t3_next_done", 32'(fd_n - fb), 1);
    chk("t3_next_err", 32'(err_n - eb), 0);

    // Short line: next hs_rise lands at hcnt 6 on the first active line.
    snap();
    frame(-1, 0, 4, -1, -1);
    chk_writes("t4", 1, 1'b0);
    chk("t4_err_n", 32'(err_n - eb), 1);
    chk("t4_done_n", 32'(fd_n - fb), 0);
    chk("t4_busy_end", 32'(busy), 0);

    // Missing hsync: hcnt saturates at 2047 on the first active line.
    snap();
    frame(-1, 0, 2100, -1, -1);
    chk_writes("t5", 4, 1'b1);
    chk("t5_err_n", 32'(err_n - eb), 1);
    chk("t5_done_n", 32'(fd_n - fb), 0);

    // capture_en dropped mid-frame: frame completes, following frame ignored.
    snap();
    frame(-1, -1, 14, 1, -1);
    chk_writes("t6", 8, 1'b1);
    chk("t6_done_n", 32'(fd_n - fb), 1);
    snap();
    frame(-1, -1, 14, -1, -1);
    chk("t6_off_writes", 32'(wr_n - wb), 0);
    chk("t6_off_done", 32'(fd_n - fb), 0);
    chk("t6_off_busy", 32'(busy_n - bb), 0);

    // One-cycle reset mid-line, then capture resumes on the next frame.
    capture_en = 1'b1;
    line(1'b1, -1, 14, -1);
    snap();
    frame(-1, -1, 14, -1, 0);
    chk_writes("t7_cut", 1, 1'b1);
    chk("t7_cut_done", 32'(fd_n - fb), 0);
    snap();
    frame(-1, -1, 14, -1, -1);
    chk_writes("t7_next", 8, 1'b1);
    chk("t7_next_done", 32'(fd_n - fb), 1);
    chk("final_we_nobusy", 32'(nobusy_n), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
